// File: rtl/mercury_ddio_pkg.sv
// Shared definitions for the mercury DDIO transmit stream.
//   ddio_state_t : burst sequencer states (2-bit encoding)
//   DDIO_CNT_W   : width of the preamble/hold down-counter
package mercury_ddio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_HOLD     = 2'd3
    } ddio_state_t;

    localparam int DDIO_CNT_W = 4;

endpackage

// File: rtl/mercury_ddio_tx_fifo2.sv
// Two-entry word FIFO feeding the DDIO transmit sequencer.
//   clk, areset_n : clock, asynchronous active-low reset
//   clkena        : clock enable; low freezes contents, pointers and count
//   push/push_data: write one word (caller guarantees count < 2)
//   pop           : discard the head word (caller guarantees count > 0)
//   head_data     : current head word (meaningful only while count > 0)
//   count         : number of stored words, 0..2
module mercury_ddio_tx_fifo2 #(
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          clkena,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem0;
    logic [DW-1:0] mem1;
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clkena) begin
            if (push) begin
                if (wr_ptr) mem1 <= push_data;
                else        mem0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            // Simultaneous push and pop leaves the count unchanged.
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    assign head_data = rd_ptr ? mem1 : mem0;

endmodule

// File: rtl/mercury_ddio_out_stream.sv
// Transmit-side DDIO stream: accepts 2*WIDTH-bit words on a valid/ready
// stream and drives one word per clock as a high/low pair to a DDIO output
// atom, wrapping each burst with an OE preamble and a trailing OE hold.
//   clk, areset_n       : clock (also the atom outclk), async active-low reset
//   clkena              : global enable; low freezes everything, in_ready = 0
//   in_data/in_valid    : input word stream; [2W-1:W] is the rising-edge half
//   in_ready            : FIFO can accept a word this cycle
//   dataout_h/dataout_l : registered halves to atom datain_h/datain_l
//   oe                  : registered output enable to the atom
//   busy                : sequencer not idle or words still queued
//   debug_state         : current sequencer state
//
// Handshake: a word transfers on every enabled rising edge where in_valid and
// in_ready are both high; in_ready depends only on registered state (never
// on in_valid or on the pop), and in_data must be stable while in_valid is
// high and in_ready low.
module mercury_ddio_out_stream
    import mercury_ddio_pkg::*;
#(
    parameter int                 WIDTH           = 1,
    parameter int                 PREAMBLE_CYCLES = 2,
    parameter int                 HOLD_CYCLES     = 1,
    parameter logic [2*WIDTH-1:0] PREAMBLE_WORD   = '0,
    parameter logic [2*WIDTH-1:0] IDLE_WORD       = '0
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic               clkena,
    input  logic [2*WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   dataout_h,
    output logic [WIDTH-1:0]   dataout_l,
    output logic               oe,
    output logic               busy,
    output logic [1:0]         debug_state
);

    localparam logic [DDIO_CNT_W-1:0] PRE_LOAD =
        DDIO_CNT_W'((PREAMBLE_CYCLES == 0) ? 0 : PREAMBLE_CYCLES - 1);
    localparam logic [DDIO_CNT_W-1:0] HOLD_LOAD =
        DDIO_CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    ddio_state_t           state, state_n;
    logic [DDIO_CNT_W-1:0] cnt, cnt_n;
    logic [2*WIDTH-1:0]    out_word, word_n;
    logic                  oe_n;
    logic                  ready_en;
    logic                  pop, push;
    logic                  take_word, end_burst;
    logic [2*WIDTH-1:0]    head_data;
    logic [1:0]            count;
    logic                  fifo_empty;

    // ready_en keeps in_ready low while in reset and until the first enabled
    // edge afterwards, without giving in_ready a combinational reset path.
    assign in_ready   = clkena & ready_en & (count < 2'd2);
    assign push       = in_valid & in_ready;
    assign fifo_empty = (count == 2'd0);

    mercury_ddio_tx_fifo2 #(.DW(2 * WIDTH)) u_fifo (
        .clk       (clk),
        .areset_n  (areset_n),
        .clkena    (clkena),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            out_word <= IDLE_WORD;
            oe       <= 1'b0;
            ready_en <= 1'b0;
        end else if (clkena) begin
            state    <= state_n;
            cnt      <= cnt_n;
            out_word <= word_n;
            oe       <= oe_n;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        word_n    = out_word;
        oe_n      = oe;
        pop       = 1'b0;
        take_word = 1'b0;
        end_burst = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (PREAMBLE_CYCLES == 0) begin
                        take_word = 1'b1;
                    end else begin
                        state_n = ST_PREAMBLE;
                        cnt_n   = PRE_LOAD;
                        word_n  = PREAMBLE_WORD;
                        oe_n    = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (cnt != '0)        cnt_n     = cnt - 1'b1;
                else if (!fifo_empty) take_word = 1'b1;
                else                  end_burst = 1'b1;
            end
            ST_DATA: begin
                // An underrun ends the burst; gaps are never padded.
                if (!fifo_empty) take_word = 1'b1;
                else             end_burst = 1'b1;
            end
            ST_HOLD: begin
                // Re-entry from HOLD goes straight to DATA without a preamble.
                if (!fifo_empty) begin
                    take_word = 1'b1;
                end else if (cnt == '0) begin
                    state_n = ST_IDLE;
                    word_n  = IDLE_WORD;
                    oe_n    = 1'b0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (take_word) begin
            state_n = ST_DATA;
            pop     = 1'b1;
            word_n  = head_data;
            oe_n    = 1'b1;
        end else if (end_burst) begin
            word_n = IDLE_WORD;
            if (HOLD_CYCLES == 0) begin
                state_n = ST_IDLE;
                oe_n    = 1'b0;
            end else begin
                state_n = ST_HOLD;
                cnt_n   = HOLD_LOAD;
                oe_n    = 1'b1;
            end
        end
    end

    assign dataout_h   = out_word[2*WIDTH-1:WIDTH];
    assign dataout_l   = out_word[WIDTH-1:0];
    assign busy        = (state != ST_IDLE) || !fifo_empty;
    assign debug_state = state;

endmodule

// File: tb/tb_mercury_ddio_out_stream.sv
// Directed bench for mercury_ddio_out_stream with WIDTH=4, PREAMBLE_CYCLES=2,
// HOLD_CYCLES=1, PREAMBLE_WORD=8'hA5, IDLE_WORD=8'h00.
module tb_mercury_ddio_out_stream;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       clkena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dataout_h;
    logic [3:0] dataout_l;
    logic       oe;
    logic       busy;
    logic [1:0] debug_state;

    int tests_run = 0;
    int tests_failed = 0;

    mercury_ddio_out_stream #(
        .WIDTH           (4),
        .PREAMBLE_CYCLES (2),
        .HOLD_CYCLES     (1),
        .PREAMBLE_WORD   (8'hA5),
        .IDLE_WORD       (8'h00)
    ) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .clkena      (clkena),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dataout_h   (dataout_h),
        .dataout_l   (dataout_l),
        .oe          (oe),
        .busy        (busy),
        .debug_state (debug_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // oe, {dataout_h,dataout_l} and state in one go
    task automatic chk_out(input string tag, input logic exp_oe, input logic [7:0] exp_word,
                           input logic [1:0] exp_state);
        chk({tag, ".oe"}, {31'd0, oe}, {31'd0, exp_oe});
        chk({tag, ".data"}, {24'd0, dataout_h, dataout_l}, {24'd0, exp_word});
        chk({tag, ".state"}, {30'd0, debug_state}, {30'd0, exp_state});
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        chk(tag, {31'd0, in_ready}, {31'd0, exp});
    endtask

    initial begin
        areset_n = 1'b0;
        clkena   = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // ---- reset state ----
        #2;
        chk_out("rst", 1'b0, 8'h00, S_IDLE);
        chk_rdy("rst.ready", 1'b0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        #10 areset_n = 1'b1;
        step();
        chk_rdy("post_rst.ready", 1'b1);
        chk_out("post_rst", 1'b0, 8'h00, S_IDLE);

        // ---- single word ----
        in_data = 8'h3C; in_valid = 1'b1;
        step();                                   // edge N: push
        in_valid = 1'b0;
        chk_out("single.N", 1'b0, 8'h00, S_IDLE);
        chk("single.busy", {31'd0, busy}, 32'd1);
        step(); chk_out("single.N1", 1'b1, 8'hA5, S_PRE);
        step(); chk_out("single.N2", 1'b1, 8'hA5, S_PRE);
        step(); chk_out("single.N3", 1'b1, 8'h3C, S_DATA);
        step(); chk_out("single.N4", 1'b1, 8'h00, S_HOLD);
        step(); chk_out("single.N5", 1'b0, 8'h00, S_IDLE);
        chk("single.idle_busy", {31'd0, busy}, 32'd0);

        // ---- back-to-back with in_valid held high ----
        in_data = 8'h11; in_valid = 1'b1;
        step();                                   // push 11
        chk_rdy("b2b.r0", 1'b1);
        in_data = 8'h22;
        step();                                   // push 22, FIFO full
        chk_out("b2b.pre1", 1'b1, 8'hA5, S_PRE);
        chk_rdy("b2b.r1", 1'b0);
        in_data = 8'h33;
        step();
        chk_out("b2b.pre2", 1'b1, 8'hA5, S_PRE);
        chk_rdy("b2b.r2", 1'b0);
        step(); chk_out("b2b.w1", 1'b1, 8'h11, S_DATA);
        chk_rdy("b2b.r3", 1'b1);
        step(); chk_out("b2b.w2", 1'b1, 8'h22, S_DATA);   // push 33 with pop 22
        chk_rdy("b2b.r4", 1'b1);
        in_data = 8'h44;
        step(); chk_out("b2b.w3", 1'b1, 8'h33, S_DATA);   // push 44 with pop 33
        in_valid = 1'b0;
        step(); chk_out("b2b.w4", 1'b1, 8'h44, S_DATA);
        step(); chk_out("b2b.hold", 1'b1, 8'h00, S_HOLD);
        step(); chk_out("b2b.idle", 1'b0, 8'h00, S_IDLE);

        // ---- re-entry from HOLD ----
        in_data = 8'h55; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step(); chk_out("reent.pre1", 1'b1, 8'hA5, S_PRE);
        step(); chk_out("reent.pre2", 1'b1, 8'hA5, S_PRE);
        step(); chk_out("reent.w55", 1'b1, 8'h55, S_DATA);
        in_data = 8'h66; in_valid = 1'b1;
        step(); in_valid = 1'b0;                  // 66 lands as HOLD begins
        chk_out("reent.hold", 1'b1, 8'h00, S_HOLD);
        step(); chk_out("reent.w66", 1'b1, 8'h66, S_DATA);
        step(); chk_out("reent.hold2", 1'b1, 8'h00, S_HOLD);
        step(); chk_out("reent.idle", 1'b0, 8'h00, S_IDLE);

        // ---- clkena gating mid-DATA ----
        in_data = 8'h77; in_valid = 1'b1;
        step();
        in_data = 8'h88;
        step();                                   // FIFO: 77, 88
        in_valid = 1'b0;
        step();
        step(); chk_out("gate.w77", 1'b1, 8'h77, S_DATA);
        clkena = 1'b0;
        in_data = 8'h99; in_valid = 1'b1;         // must be ignored
        #1 chk_rdy("gate.ready_low", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("gate.frozen", 1'b1, 8'h77, S_DATA);
            chk_rdy("gate.frozen_ready", 1'b0);
            chk("gate.busy", {31'd0, busy}, 32'd1);
        end
        in_valid = 1'b0;
        clkena = 1'b1;
        step(); chk_out("gate.w88", 1'b1, 8'h88, S_DATA);
        step(); chk_out("gate.hold", 1'b1, 8'h00, S_HOLD);
        step(); chk_out("gate.idle", 1'b0, 8'h00, S_IDLE);

        // ---- backpressure in PREAMBLE ----
        in_data = 8'hAA; in_valid = 1'b1;
        step();
        in_data = 8'hBB;
        step();                                   // FIFO full
        in_data = 8'hEE;                          // offered while full
        chk_rdy("bp.full1", 1'b0);
        step();
        chk_out("bp.pre2", 1'b1, 8'hA5, S_PRE);
        chk_rdy("bp.full2", 1'b0);
        step(); chk_out("bp.wAA", 1'b1, 8'hAA, S_DATA);
        chk_rdy("bp.count1", 1'b1);
        in_data = 8'hCC;
        step(); chk_out("bp.wBB", 1'b1, 8'hBB, S_DATA);   // pop BB + push CC
        chk_rdy("bp.still1", 1'b1);
        in_valid = 1'b0;
        step(); chk_out("bp.wCC", 1'b1, 8'hCC, S_DATA);
        step(); chk_out("bp.hold", 1'b1, 8'h00, S_HOLD);
        step(); chk_out("bp.idle", 1'b0, 8'h00, S_IDLE);

        // ---- async reset mid-DATA ----
        in_data = 8'h01; in_valid = 1'b1;
        step();
        in_data = 8'h02;
        step();
        in_data = 8'h03;
        step();
        step(); chk_out("ar.w01", 1'b1, 8'h01, S_DATA);   // 02 queued, 03 about to push
        step(); chk_out("ar.w02", 1'b1, 8'h02, S_DATA);   // 03 queued
        in_valid = 1'b0;
        #2 areset_n = 1'b0;
        #1;
        chk_out("ar.in_reset", 1'b0, 8'h00, S_IDLE);
        chk("ar.busy", {31'd0, busy}, 32'd0);
        chk_rdy("ar.ready", 1'b0);
        #2 areset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("ar.no_stale", 1'b0, 8'h00, S_IDLE);
            chk("ar.idle_busy", {31'd0, busy}, 32'd0);
        end
        in_data = 8'h5A; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step(); chk_out("ar.pre1", 1'b1, 8'hA5, S_PRE);
        step(); chk_out("ar.pre2", 1'b1, 8'hA5, S_PRE);
        step(); chk_out("ar.w5A", 1'b1, 8'h5A, S_DATA);
        step(); chk_out("ar.hold", 1'b1, 8'h00, S_HOLD);
        step(); chk_out("ar.idle", 1'b0, 8'h00, S_IDLE);

        // ---- report ----
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
